clock_set_ctrl: RTL and testbench

- Mode/edit controller for the 8-digit HH-MM-SS display.
- Sits between the timekeeper and the LED scan datapath, and generates that datapath's digit codes plus its point, is_shine and which_shine configuration.
- Runs a RUN / SET_H / SET_M / SET_S state machine driven by pre-debounced button pulses.
- Edits a BCD time buffer and drives the field-blink controls.
- Commits the edited time to the timekeeper with a one-cycle load pulse.

---
 rtl/clock_set_ctrl.sv | 165 ++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: mode/edit controller for the 8-digit HH-MM-SS display.
// Drives the scan datapath (digit codes, points, blink controls) and commits
// an edited BCD time to the timekeeper with a one-cycle set_load strobe.
module clock_set_ctrl #(
  parameter int          BLINK_DIV = 25000000,
  parameter logic [3:0]  SEP_CODE  = 4'hA
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_esc,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [7:0] cur_h,
  input  logic [7:0] cur_m,
  input  logic [7:0] cur_s,
  output logic [3:0] led1Number,
  output logic [3:0] led2Number,
  output logic [3:0] led3Number,
  output logic [3:0] led4Number,
  output logic [3:0] led5Number,
  output logic [3:0] led6Number,
  output logic [3:0] led7Number,
  output logic [3:0] led8Number,
  output logic [7:0] point,
  output logic [7:0] which_shine,
  output logic       is_shine,
  output logic       set_load,
  output logic [7:0] set_h,
  output logic [7:0] set_m,
  output logic [7:0] set_s
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {RUN, SET_H, SET_M, SET_S} state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_bh, r_bm, r_bs;
  logic [7:0]    w_bh_nxt, w_bm_nxt, w_bs_nxt;
  logic [7:0]    w_dh, w_dm, w_ds;
  logic [CW-1:0] r_cnt;
  logic          w_load_nxt;
  logic          w_blink_rst;

  // One BCD step within 00..max; tens/ones stay decimal, wraps at both ends.
  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic up,
                                          input logic [7:0] max);
    logic [7:0] r;
    if (up) begin
      if (v == max)           r = 8'h00;
      else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
      else                    r = {v[7:4], v[3:0] + 4'd1};
    end else begin
      if (v == 8'h00)         r = max;
      else if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'd9};
      else                    r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  // Next state, edit buffer, commit strobe and blink restart; esc > mode > up/down.
  always_comb begin
    w_state_nxt = r_state;
    w_bh_nxt    = r_bh;
    w_bm_nxt    = r_bm;
    w_bs_nxt    = r_bs;
    w_load_nxt  = 1'b0;
    w_blink_rst = 1'b0;
    if (r_state == RUN) begin
      if (btn_mode) begin
        w_state_nxt = SET_H;
        w_bh_nxt    = cur_h;
        w_bm_nxt    = cur_m;
        w_bs_nxt    = cur_s;
        w_blink_rst = 1'b1;
      end
    end else if (btn_esc) begin
      w_state_nxt = RUN;
    end else if (btn_mode) begin
      w_blink_rst = 1'b1;
      case (r_state)
        SET_H:   w_state_nxt = SET_M;
        SET_M:   w_state_nxt = SET_S;
        default: begin
          w_state_nxt = RUN;
          w_load_nxt  = 1'b1;
        end
      endcase
    end else if (btn_up ^ btn_down) begin
      w_blink_rst = 1'b1;
      case (r_state)
        SET_H:   w_bh_nxt = bcd_step(r_bh, btn_up, 8'h23);
        SET_M:   w_bm_nxt = bcd_step(r_bm, btn_up, 8'h59);
        default: w_bs_nxt = bcd_step(r_bs, btn_up, 8'h59);
      endcase
    end
    // Displayed time: live in RUN, edit buffer while editing.
    w_dh = (w_state_nxt == RUN) ? cur_h : w_bh_nxt;
    w_dm = (w_state_nxt == RUN) ? cur_m : w_bm_nxt;
    w_ds = (w_state_nxt == RUN) ? cur_s : w_bs_nxt;
  end

  // State, buffer, blink phase and all registered display outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RUN;
      r_bh        <= 8'h00;
      r_bm        <= 8'h00;
      r_bs        <= 8'h00;
      r_cnt       <= '0;
      is_shine    <= 1'b0;
      set_load    <= 1'b0;
      point       <= 8'h00;
      which_shine <= 8'h00;
      led1Number  <= 4'h0;
      led2Number  <= 4'h0;
      led3Number  <= 4'h0;
      led4Number  <= 4'h0;
      led5Number  <= 4'h0;
      led6Number  <= 4'h0;
      led7Number  <= 4'h0;
      led8Number  <= 4'h0;
    end else begin
      r_state  <= w_state_nxt;
      r_bh     <= w_bh_nxt;
      r_bm     <= w_bm_nxt;
      r_bs     <= w_bs_nxt;
      set_load <= w_load_nxt;
      if (w_state_nxt == RUN) begin
        r_cnt    <= '0;
        is_shine <= 1'b0;
      end else if (w_blink_rst) begin
        r_cnt    <= '0;
        is_shine <= 1'b1;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt    <= '0;
        is_shine <= ~is_shine;
      end else begin
        r_cnt    <= r_cnt + 1'b1;
      end
      point <= (w_state_nxt == RUN) ? 8'h00 : 8'h80;
      case (w_state_nxt)
        SET_H:   which_shine <= 8'hC0;
        SET_M:   which_shine <= 8'h18;
        SET_S:   which_shine <= 8'h03;
        default: which_shine <= 8'h00;
      endcase
      led8Number <= w_dh[7:4];
      led7Number <= w_dh[3:0];
      led6Number <= SEP_CODE;
      led5Number <= w_dm[7:4];
      led4Number <= w_dm[3:0];
      led3Number <= SEP_CODE;
      led2Number <= w_ds[7:4];
      led1Number <= w_ds[3:0];
    end
  end

  assign set_h = r_bh;
  assign set_m = r_bm;
  assign set_s = r_bs;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with a short blink period.
module tb_clock_set_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode, btn_esc, btn_up, btn_down;
  logic [7:0] cur_h, cur_m, cur_s;
  logic [3:0] led1Number, led2Number, led3Number, led4Number;
  logic [3:0] led5Number, led6Number, led7Number, led8Number;
  logic [7:0] point, which_shine, set_h, set_m, set_s;
  logic       is_shine, set_load;
  logic [31:0] digits;
  int n_cmp = 0;
  int n_err = 0;

  clock_set_ctrl #(.BLINK_DIV(4), .SEP_CODE(4'hA)) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_esc(btn_esc), .btn_up(btn_up), .btn_down(btn_down),
    .cur_h(cur_h), .cur_m(cur_m), .cur_s(cur_s),
    .led1Number(led1Number), .led2Number(led2Number), .led3Number(led3Number),
    .led4Number(led4Number), .led5Number(led5Number), .led6Number(led6Number),
    .led7Number(led7Number), .led8Number(led8Number),
    .point(point), .which_shine(which_shine), .is_shine(is_shine),
    .set_load(set_load), .set_h(set_h), .set_m(set_m), .set_s(set_s)
  );

  always #5 clk = ~clk;
  assign digits = {led8Number, led7Number, led6Number, led5Number,
                   led4Number, led3Number, led2Number, led1Number};

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Hold the given buttons for exactly one rising edge.
  task automatic press(input logic m, input logic e, input logic u, input logic d);
    btn_mode = m; btn_esc = e; btn_up = u; btn_down = d;
    @(negedge clk);
    btn_mode = 0; btn_esc = 0; btn_up = 0; btn_down = 0;
  endtask

  task automatic test_reset;
    reset = 1; cur_h = 8'h12; cur_m = 8'h34; cur_s = 8'h56;
    btn_mode = 0; btn_esc = 0; btn_up = 0; btn_down = 0;
    tick(2);
    n_cmp++; if (digits !== 32'h0) begin n_err++; $display("FAIL rst_digits got %h want 00000000", digits); end
    n_cmp++; if ({point, which_shine, is_shine, set_load} !== 18'h0) begin n_err++;
      $display("FAIL rst_ctrl got pt=%h ws=%h sh=%b ld=%b want 0", point, which_shine, is_shine, set_load); end
    reset = 0;
    tick(1);
    n_cmp++; if (digits !== 32'h12A34A56) begin n_err++; $display("FAIL run_digits got %h want 12A34A56", digits); end
    n_cmp++; if ({point, which_shine, is_shine, set_load} !== 18'h0) begin n_err++;
      $display("FAIL run_ctrl got pt=%h ws=%h sh=%b ld=%b want 0", point, which_shine, is_shine, set_load); end
    press(0, 0, 1, 0); // ignored in RUN
    n_cmp++; if (digits !== 32'h12A34A56 || which_shine !== 8'h00) begin n_err++;
      $display("FAIL run_up_ignored got %h ws=%h want 12A34A56 ws=00", digits, which_shine); end
  endtask

  task automatic test_set_hours;
    cur_h = 8'h23; cur_m = 8'h59; cur_s = 8'h58;
    tick(1);
    press(1, 0, 0, 0);
    n_cmp++; if (which_shine !== 8'hC0 || is_shine !== 1'b1 || point !== 8'h80) begin n_err++;
      $display("FAIL enter_seth got ws=%h sh=%b pt=%h want C0 1 80", which_shine, is_shine, point); end
    n_cmp++; if (digits !== 32'h23A59A58) begin n_err++; $display("FAIL enter_digits got %h want 23A59A58", digits); end
    press(0, 0, 1, 0);
    n_cmp++; if (digits !== 32'h00A59A58) begin n_err++; $display("FAIL h_up_wrap got %h want 00A59A58", digits); end
    press(0, 0, 0, 1);
    n_cmp++; if (digits !== 32'h23A59A58) begin n_err++; $display("FAIL h_down_wrap got %h want 23A59A58", digits); end
    press(0, 0, 0, 1);
    n_cmp++; if (digits !== 32'h22A59A58) begin n_err++; $display("FAIL h_down got %h want 22A59A58", digits); end
    press(0, 1, 0, 0);
  endtask

  task automatic test_blink;
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    n_cmp++; if (which_shine !== 8'h18 || is_shine !== 1'b1) begin n_err++;
      $display("FAIL setm_entry got ws=%h sh=%b want 18 1", which_shine, is_shine); end
    tick(3);
    n_cmp++; if (is_shine !== 1'b1) begin n_err++; $display("FAIL blink_hold got %b want 1", is_shine); end
    tick(1);
    n_cmp++; if (is_shine !== 1'b0) begin n_err++; $display("FAIL blink_toggle got %b want 0", is_shine); end
    tick(2);
    n_cmp++; if (is_shine !== 1'b0) begin n_err++; $display("FAIL blink_mid got %b want 0", is_shine); end
    press(0, 0, 1, 0);
    n_cmp++; if (is_shine !== 1'b1 || digits !== 32'h23A00A58) begin n_err++;
      $display("FAIL m_up_wrap got sh=%b %h want 1 23A00A58", is_shine, digits); end
    tick(3);
    n_cmp++; if (is_shine !== 1'b1) begin n_err++; $display("FAIL blink_restart got %b want 1", is_shine); end
    tick(1);
    n_cmp++; if (is_shine !== 1'b0) begin n_err++; $display("FAIL blink_restart_tgl got %b want 0", is_shine); end
    press(0, 1, 0, 0);
  endtask

  task automatic test_full_sequence;
    cur_h = 8'h12; cur_m = 8'h34; cur_s = 8'h56;
    tick(1);
    press(1, 0, 0, 0); press(0, 0, 1, 0);
    press(1, 0, 0, 0); press(0, 0, 0, 1);
    press(1, 0, 0, 0); press(0, 0, 1, 0);
    n_cmp++; if (digits !== 32'h13A33A57 || which_shine !== 8'h03 || set_load !== 1'b0) begin n_err++;
      $display("FAIL pre_commit got %h ws=%h ld=%b want 13A33A57 03 0", digits, which_shine, set_load); end
    press(1, 0, 0, 0);
    n_cmp++; if (set_load !== 1'b1 || {set_h, set_m, set_s} !== 24'h133357) begin n_err++;
      $display("FAIL commit got ld=%b %h%h%h want 1 133357", set_load, set_h, set_m, set_s); end
    n_cmp++; if (which_shine !== 8'h00 || is_shine !== 1'b0 || point !== 8'h00 || digits !== 32'h12A34A56) begin n_err++;
      $display("FAIL commit_run got ws=%h sh=%b pt=%h %h want 00 0 00 12A34A56", which_shine, is_shine, point, digits); end
    tick(1);
    n_cmp++; if (set_load !== 1'b0) begin n_err++; $display("FAIL load_one_cycle got %b want 0", set_load); end
  endtask

  task automatic test_esc;
    press(1, 0, 0, 0); press(1, 0, 0, 0); press(1, 0, 0, 0);
    press(0, 0, 1, 0);
    cur_h = 8'h01; cur_m = 8'h02; cur_s = 8'h03;
    tick(1);
    n_cmp++; if (digits !== 32'h12A34A57) begin n_err++; $display("FAIL cur_ignored got %h want 12A34A57", digits); end
    press(0, 1, 0, 0);
    n_cmp++; if (set_load !== 1'b0 || which_shine !== 8'h00 || digits !== 32'h01A02A03) begin n_err++;
      $display("FAIL esc got ld=%b ws=%h %h want 0 00 01A02A03", set_load, which_shine, digits); end
    tick(1);
    n_cmp++; if (set_load !== 1'b0) begin n_err++; $display("FAIL esc_noload got %b want 0", set_load); end
  endtask

  task automatic test_back_to_back;
    press(1, 0, 0, 0);
    press(1, 0, 1, 0);
    n_cmp++; if (which_shine !== 8'h18 || digits !== 32'h01A02A03) begin n_err++;
      $display("FAIL mode_over_up got ws=%h %h want 18 01A02A03", which_shine, digits); end
    press(0, 0, 0, 1); press(0, 0, 0, 1); press(0, 0, 0, 1);
    n_cmp++; if (digits !== 32'h01A59A03) begin n_err++; $display("FAIL m_down_wrap got %h want 01A59A03", digits); end
    press(0, 0, 1, 1);
    n_cmp++; if (digits !== 32'h01A59A03) begin n_err++; $display("FAIL up_down got %h want 01A59A03", digits); end
    press(1, 1, 0, 0);
    n_cmp++; if (which_shine !== 8'h00 || set_load !== 1'b0) begin n_err++;
      $display("FAIL esc_over_mode got ws=%h ld=%b want 00 0", which_shine, set_load); end
    press(1, 0, 0, 0); press(1, 0, 0, 0);
    reset = 1;
    tick(1);
    reset = 0;
    n_cmp++; if (digits !== 32'h0 || {point, which_shine, is_shine, set_load} !== 18'h0 ||
                 {set_h, set_m, set_s} !== 24'h0) begin n_err++;
      $display("FAIL mid_reset got %h pt=%h ws=%h sh=%b ld=%b buf=%h%h%h want all 0",
               digits, point, which_shine, is_shine, set_load, set_h, set_m, set_s); end
    tick(1);
    n_cmp++; if (set_load !== 1'b0 || which_shine !== 8'h00) begin n_err++;
      $display("FAIL post_reset got ld=%b ws=%h want 0 00", set_load, which_shine); end
  endtask

  initial begin
    test_reset();
    test_set_hours();
    test_blink();
    test_full_sequence();
    test_esc();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
